// File: rtl/lut_pkg.sv
// ---------------------------------------------------------------------------
// lut_pkg
// Shared definitions for the ping-pong lookup table:
//   DEFAULT_DATA_W / DEFAULT_ADDR_W / DEFAULT_NUM_RD - default parameter values
//   bank_idx_t  - index of one of the two table banks
//   lut_depth() - number of entries per bank for a given address width
// ---------------------------------------------------------------------------
package lut_pkg;

    localparam int DEFAULT_DATA_W = 11;
    localparam int DEFAULT_ADDR_W = 11;
    localparam int DEFAULT_NUM_RD = 2;

    typedef logic bank_idx_t;

    function automatic int lut_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage : lut_pkg

// File: rtl/lut_bank_ram.sv
// ---------------------------------------------------------------------------
// lut_bank_ram
// One table bank: a single write port and NUM_RD registered read ports.
// Each read port owns a private copy of the array, so every copy is a plain
// simple dual-port memory (one write, one read) that maps onto BRAM/LUTRAM.
// Reads are read-before-write: a same-cycle write to the addressed entry
// returns the old contents.
// Ports:
//   clk      in   clock
//   we       in   write enable
//   waddr    in   ADDR_W write address
//   wdata    in   DATA_W write data
//   rd_en    in   NUM_RD per-port read enable (output holds when low)
//   rd_addr  in   NUM_RD*ADDR_W packed read addresses
//   rd_data  out  NUM_RD*DATA_W packed registered read data
// ---------------------------------------------------------------------------
module lut_bank_ram
    import lut_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int NUM_RD = DEFAULT_NUM_RD
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data
);

    localparam int DEPTH = lut_depth(ADDR_W);

    for (genvar g = 0; g < NUM_RD; g++) begin : g_port
        logic [DATA_W-1:0] mem [DEPTH];
        logic [DATA_W-1:0] q;

        // NOTE: the array and its read register carry no reset; a reset on
        // memory contents prevents mapping onto RAM primitives. The top masks
        // read data until a complete table has been promoted.
        always_ff @(posedge clk) begin
            if (we) begin
                mem[waddr] <= wdata;
            end
            if (rd_en[g]) begin
                q <= mem[rd_addr[g*ADDR_W +: ADDR_W]];
            end
        end

        assign rd_data[g*DATA_W +: DATA_W] = q;
    end

endmodule : lut_bank_ram

// File: rtl/pingpong_lut.sv
// ---------------------------------------------------------------------------
// pingpong_lut
// Double-buffered lookup table. Software streams a table into the shadow
// bank while the datapath reads the active bank; a swap request promotes a
// complete shadow bank atomically. NUM_RD independent read channels, each
// with 1-cycle latency.
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   wr_data, wr_valid  sequential load into the shadow bank
//   wr_ready           shadow bank accepts entries
//   load_restart       abort the load, rewind the shadow pointer
//   shadow_full        shadow bank complete, ready to swap
//   wr_count           entries loaded so far (ADDR_W+1 bits)
//   swap_req           promote the shadow bank
//   swap_ack/swap_err  1-cycle pulses: swap done / swap rejected
//   active_bank        index of the bank being read
//   active_valid       active bank holds a complete table
//   rd_addr, rd_en     packed per-channel read address and strobe
//   rd_data, rd_valid  packed per-channel read data and valid
// ---------------------------------------------------------------------------
module pingpong_lut
    import lut_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int NUM_RD = DEFAULT_NUM_RD
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic                     load_restart,
    output logic                     shadow_full,
    output logic [ADDR_W:0]          wr_count,
    input  logic                     swap_req,
    output logic                     swap_ack,
    output logic                     swap_err,
    output logic                     active_bank,
    output logic                     active_valid,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    input  logic [NUM_RD-1:0]        rd_en,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid
);

    localparam logic [ADDR_W-1:0] PTR_LAST = '1;

    // Load / swap state
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   wr_count_q;
    logic              shadow_full_q;
    logic              swap_ack_q;
    logic              swap_err_q;
    bank_idx_t         active_bank_q;
    logic [1:0]        bank_valid;

    // Per-channel read bookkeeping: which bank the last accepted read came
    // from, and whether its data must be forced to zero.
    logic [NUM_RD-1:0] rd_valid_q;
    logic [NUM_RD-1:0] rd_bank_q;
    logic [NUM_RD-1:0] rd_zero_q;

    logic                     do_write;
    logic                     swap_ok;
    logic [1:0]               bank_we;
    logic [NUM_RD*DATA_W-1:0] bank_rd_data [2];

    assign wr_ready     = !shadow_full_q && !load_restart;
    assign do_write     = wr_valid && wr_ready;
    assign swap_ok      = swap_req && shadow_full_q && !load_restart;
    assign active_valid = bank_valid[active_bank_q];

    assign shadow_full = shadow_full_q;
    assign wr_count    = wr_count_q;
    assign swap_ack    = swap_ack_q;
    assign swap_err    = swap_err_q;
    assign active_bank = active_bank_q;
    assign rd_valid    = rd_valid_q;

    // Writes only ever target the shadow bank, so reads never see them.
    assign bank_we[0] = do_write && (active_bank_q != 1'b0);
    assign bank_we[1] = do_write && (active_bank_q != 1'b1);

    for (genvar b = 0; b < 2; b++) begin : g_bank
        lut_bank_ram #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .NUM_RD (NUM_RD)
        ) u_bank (
            .clk     (clk),
            .we      (bank_we[b]),
            .waddr   (wr_ptr),
            .wdata   (wr_data),
            .rd_en   (rd_en),
            .rd_addr (rd_addr),
            .rd_data (bank_rd_data[b])
        );
    end

    // Load pointer, swap control and bank bookkeeping. load_restart has
    // priority over a swap; a swap can never coincide with a write because a
    // swap needs shadow_full, which blocks writes.
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr        <= '0;
            wr_count_q    <= '0;
            shadow_full_q <= 1'b0;
            swap_ack_q    <= 1'b0;
            swap_err_q    <= 1'b0;
            active_bank_q <= 1'b0;
            bank_valid    <= 2'b00;
        end else begin
            swap_ack_q <= swap_ok;
            swap_err_q <= swap_req && !swap_ok;

            if (load_restart) begin
                wr_ptr        <= '0;
                wr_count_q    <= '0;
                shadow_full_q <= 1'b0;
            end else if (swap_ok) begin
                active_bank_q <= !active_bank_q;
                // New active bank is valid, the new shadow bank is not.
                bank_valid    <= active_bank_q ? 2'b01 : 2'b10;
                shadow_full_q <= 1'b0;
                wr_ptr        <= '0;
                wr_count_q    <= '0;
            end else if (do_write) begin
                // The pointer wraps to 0 on the last entry by its own width.
                wr_ptr     <= wr_ptr + ADDR_W'(1);
                wr_count_q <= wr_count_q + (ADDR_W + 1)'(1);
                if (wr_ptr == PTR_LAST) begin
                    shadow_full_q <= 1'b1;
                end
            end
        end
    end

    // Read channels: the bank RAMs register the data; here we remember the
    // bank and validity seen at request time. Without rd_en, valid drops and
    // the data (RAM register and these flags) simply holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_q <= '0;
            rd_bank_q  <= '0;
            rd_zero_q  <= '1;
        end else begin
            for (int i = 0; i < NUM_RD; i++) begin
                if (rd_en[i]) begin
                    rd_valid_q[i] <= active_valid;
                    rd_bank_q[i]  <= active_bank_q;
                    rd_zero_q[i]  <= !active_valid;
                end else begin
                    rd_valid_q[i] <= 1'b0;
                end
            end
        end
    end

    // NOTE: combinational outputs get a default first so no path leaves them
    // unassigned, which would infer a latch.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (!rd_zero_q[i]) begin
                rd_data[i*DATA_W +: DATA_W] = bank_rd_data[rd_bank_q[i]][i*DATA_W +: DATA_W];
            end
        end
    end

endmodule : pingpong_lut

// File: tb/tb_pingpong_lut.sv
// ---------------------------------------------------------------------------
// tb_pingpong_lut
// Directed self-checking bench for pingpong_lut with ADDR_W=3 (8 entries per
// bank), DATA_W=11, NUM_RD=2. Inputs change 1 ns after a rising edge and
// outputs are sampled there too, away from the active edge.
// ---------------------------------------------------------------------------
module tb_pingpong_lut;

    localparam int DATA_W = 11;
    localparam int ADDR_W = 3;
    localparam int NUM_RD = 2;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic [DATA_W-1:0]        wr_data;
    logic                     wr_valid;
    logic                     wr_ready;
    logic                     load_restart;
    logic                     shadow_full;
    logic [ADDR_W:0]          wr_count;
    logic                     swap_req;
    logic                     swap_ack;
    logic                     swap_err;
    logic                     active_bank;
    logic                     active_valid;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_valid;

    int n_cmp = 0;
    int n_err = 0;

    pingpong_lut #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_data      (wr_data),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .load_restart (load_restart),
        .shadow_full  (shadow_full),
        .wr_count     (wr_count),
        .swap_req     (swap_req),
        .swap_ack     (swap_ack),
        .swap_err     (swap_err),
        .active_bank  (active_bank),
        .active_valid (active_valid),
        .rd_addr      (rd_addr),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pack2(input int ch1, input int ch0);
        logic [NUM_RD*DATA_W-1:0] v;
        v = {DATA_W'(ch1), DATA_W'(ch0)};
        return 32'(v);
    endfunction

    initial begin
        reset_n      = 1'b0;
        wr_data      = '0;
        wr_valid     = 1'b0;
        load_restart = 1'b0;
        swap_req     = 1'b0;
        rd_addr      = '0;
        rd_en        = '0;
        tick();
        tick();

        // Reset values
        check("rst_wr_count", 32'(wr_count), 32'd0);
        check("rst_shadow_full", 32'(shadow_full), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        check("rst_active_bank", 32'(active_bank), 32'd0);
        check("rst_active_valid", 32'(active_valid), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_swap_pulses", 32'({swap_ack, swap_err}), 32'd0);
        reset_n = 1'b1;
        tick();

        // Read before any table is active: valid low, data zero
        rd_en = 2'b11;
        rd_addr = '0;
        tick();
        check("empty_rd_valid", 32'(rd_valid), 32'd0);
        check("empty_rd_data", 32'(rd_data), 32'd0);
        check("empty_active_valid", 32'(active_valid), 32'd0);
        rd_en = 2'b00;

        // Swap with empty shadow is rejected
        swap_req = 1'b1;
        tick();
        check("empty_swap_err", 32'(swap_err), 32'd1);
        check("empty_swap_ack", 32'(swap_ack), 32'd0);
        check("empty_swap_bank", 32'(active_bank), 32'd0);
        swap_req = 1'b0;
        tick();
        check("swap_err_pulse_end", 32'(swap_err), 32'd0);

        // Load 100..107
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1'b1;
            wr_data  = DATA_W'(100 + i);
            tick();
            if (i == 3) check("load_count_4", 32'(wr_count), 32'd4);
        end
        check("load_count_8", 32'(wr_count), 32'd8);
        check("load_full", 32'(shadow_full), 32'd1);
        check("load_wr_ready", 32'(wr_ready), 32'd0);

        // 9th write is dropped
        wr_data = DATA_W'(999);
        tick();
        check("drop_count", 32'(wr_count), 32'd8);
        check("drop_full", 32'(shadow_full), 32'd1);
        wr_valid = 1'b0;

        // Promote the table
        swap_req = 1'b1;
        tick();
        check("swap1_ack", 32'(swap_ack), 32'd1);
        check("swap1_err", 32'(swap_err), 32'd0);
        check("swap1_bank", 32'(active_bank), 32'd1);
        check("swap1_active_valid", 32'(active_valid), 32'd1);
        check("swap1_full", 32'(shadow_full), 32'd0);
        check("swap1_count", 32'(wr_count), 32'd0);
        swap_req = 1'b0;
        tick();
        check("swap1_ack_pulse_end", 32'(swap_ack), 32'd0);

        // ch0 addr 3, ch1 addr 7 in one cycle
        rd_en   = 2'b11;
        rd_addr = {3'd7, 3'd3};
        tick();
        check("dual_rd_data", 32'(rd_data), pack2(107, 103));
        check("dual_rd_valid", 32'(rd_valid), 32'd3);
        rd_en   = 2'b00;
        rd_addr = '0;
        tick();
        check("hold_rd_data", 32'(rd_data), pack2(107, 103));
        check("hold_rd_valid", 32'(rd_valid), 32'd0);

        // Same address on both channels; entry 0 must not be the dropped write
        rd_en = 2'b11;
        tick();
        check("addr0_rd_data", 32'(rd_data), pack2(100, 100));
        rd_en = 2'b00;

        // Load 200..207 while ch0 keeps reading addr 5
        rd_en   = 2'b01;
        rd_addr = {3'd0, 3'd5};
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1'b1;
            wr_data  = DATA_W'(200 + i);
            tick();
            check("stream_ch0", 32'(rd_data[DATA_W-1:0]), 32'd105);
        end
        wr_valid = 1'b0;
        check("stream_full", 32'(shadow_full), 32'd1);

        // Swap cycle read comes from the old bank, next read from the new one
        swap_req = 1'b1;
        tick();
        check("swap2_ack", 32'(swap_ack), 32'd1);
        check("swap2_old_data", 32'(rd_data[DATA_W-1:0]), 32'd105);
        check("swap2_bank", 32'(active_bank), 32'd0);
        swap_req = 1'b0;
        tick();
        check("swap2_new_data", 32'(rd_data[DATA_W-1:0]), 32'd205);
        check("swap2_rd_valid", 32'(rd_valid), 32'd1);
        rd_en = 2'b00;

        // Partial load, then restart with a same-cycle write and swap_req
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_data  = DATA_W'(300 + i);
            tick();
        end
        check("partial_count", 32'(wr_count), 32'd4);
        load_restart = 1'b1;
        swap_req     = 1'b1;
        wr_data      = DATA_W'(999);
        #1;
        check("restart_wr_ready", 32'(wr_ready), 32'd0);
        tick();
        check("restart_count", 32'(wr_count), 32'd0);
        check("restart_full", 32'(shadow_full), 32'd0);
        check("restart_swap_err", 32'(swap_err), 32'd1);
        check("restart_swap_ack", 32'(swap_ack), 32'd0);
        load_restart = 1'b0;
        swap_req     = 1'b0;

        // Reload from entry 0
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1'b1;
            wr_data  = DATA_W'(400 + i);
            tick();
        end
        wr_valid = 1'b0;
        check("reload_full", 32'(shadow_full), 32'd1);
        check("reload_count", 32'(wr_count), 32'd8);

        // Held swap_req: ack, then err
        swap_req = 1'b1;
        tick();
        check("held_ack", 32'(swap_ack), 32'd1);
        check("held_bank", 32'(active_bank), 32'd1);
        tick();
        check("held_err", 32'(swap_err), 32'd1);
        check("held_no_ack", 32'(swap_ack), 32'd0);
        check("held_bank_stays", 32'(active_bank), 32'd1);
        swap_req = 1'b0;

        // Reloaded table starts at entry 0
        rd_en   = 2'b11;
        rd_addr = {3'd0, 3'd3};
        tick();
        check("reload_rd_data", 32'(rd_data), pack2(400, 403));
        check("reload_rd_valid", 32'(rd_valid), 32'd3);

        // Mid-load asynchronous reset clears everything at once
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1;
            wr_data  = DATA_W'(500 + i);
            tick();
        end
        check("midload_count", 32'(wr_count), 32'd3);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_wr_count", 32'(wr_count), 32'd0);
        check("async_active_bank", 32'(active_bank), 32'd0);
        check("async_active_valid", 32'(active_valid), 32'd0);
        check("async_rd_data", 32'(rd_data), 32'd0);
        check("async_rd_valid", 32'(rd_valid), 32'd0);
        check("async_full", 32'(shadow_full), 32'd0);
        wr_valid = 1'b0;
        rd_en    = 2'b00;
        tick();
        reset_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_pingpong_lut

// File: doc/pingpong_lut.md
Name: pingpong_lut

Overview:
Double-buffered, parametrised successor to the divider lookup table. Software streams a new table into the shadow bank while the datapath keeps reading the active bank. A swap request then atomically promotes the shadow bank, so coefficient reloads need no downtime. It serves NUM_RD independent read channels (e.g. I and Q dividers), each with 1-cycle latency, and sits between the control register bus and the DSP datapath.

Parameters:
DATA_W, 11, table entry width
ADDR_W, 11, address width; DEPTH = 2**ADDR_W entries per bank
NUM_RD, 2, number of independent read channels

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
wr_data  in  DATA_W  load data; written sequentially into the shadow bank
wr_valid  in  1  load strobe
wr_ready  out  1  high while the shadow bank is accepting entries
load_restart  in  1  abort the current load and rewind the shadow pointer to 0
shadow_full  out  1  shadow bank holds DEPTH entries and is ready to swap
wr_count  out  ADDR_W+1  entries loaded into the shadow bank so far
swap_req  in  1  request promotion of the shadow bank
swap_ack  out  1  1-cycle pulse: swap done
swap_err  out  1  1-cycle pulse: swap rejected
active_bank  out  1  index of the bank being read
active_valid  out  1  active bank holds a complete table
rd_addr  in  NUM_RD*ADDR_W  packed read addresses, channel i at [i*ADDR_W +: ADDR_W]
rd_en  in  NUM_RD  per-channel read strobe
rd_data  out  NUM_RD*DATA_W  packed read data, 1-cycle latency
rd_valid  out  NUM_RD  per-channel valid, 1-cycle latency

Behaviour:
- Reset (async assert, sync release) clears the following to 0: wr_ptr, wr_count, shadow_full, swap_ack, swap_err, active_bank, bank_valid[1:0], rd_data, rd_valid. RAM contents are not reset.
- wr_ready = !shadow_full && !load_restart (combinational).
- Load: wr_valid && wr_ready writes shadow[wr_ptr] (shadow = !active_bank), then wr_ptr++ and wr_count++.
  - The write at wr_ptr == DEPTH-1 sets shadow_full next cycle, wraps wr_ptr to 0, and leaves wr_count == DEPTH.
  - wr_valid while !wr_ready is dropped, with no side effects.
- load_restart: next cycle wr_ptr = 0, wr_count = 0, shadow_full = 0. It beats a same-cycle write and a same-cycle swap_req; that swap_req yields swap_err.
- Swap: swap_req && shadow_full && !load_restart causes, next cycle:
  - active_bank toggles;
  - bank_valid[new active] = 1 and bank_valid[new shadow] = 0;
  - shadow_full = 0, wr_ptr = 0, wr_count = 0;
  - swap_ack = 1 for one cycle.
- swap_req && !shadow_full: swap_err pulses for one cycle; no state change.
- swap_req held high is edge-insensitive: each high cycle is evaluated independently. After a successful swap, shadow_full = 0, so a held request produces swap_err pulses.
- Read, channel i: rd_en[i] at cycle t gives, at t+1:
  - rd_valid[i] = active_valid as seen at t;
  - rd_data[i] = bank[active_bank at t][rd_addr_i] if valid, else 0.
- When rd_en[i] is low: rd_valid[i] = 0 next cycle and rd_data[i] holds its last value.
- Read in the swap cycle: served from the old bank. The new bank is seen from the following cycle.
- Reads never observe shadow-bank writes, because writes only target the shadow bank.
- Channels are fully independent; identical addresses on several channels in the same cycle are legal.
- active_valid = bank_valid[active_bank]. It is 0 after reset until the first successful swap.
- Reset mid-load or mid-swap: all state returns to the reset values; the partial load is lost.

Decomposition:
- pkg lut_pkg: default DATA_W/ADDR_W constants, DEPTH function, bank index typedef.
- Sub-module lut_bank_ram (one per bank): 1 write port, NUM_RD registered read ports, no reset, read-before-write. It is implemented as NUM_RD replicated simple dual-port arrays so it maps to BRAM/LUTRAM.
- Top: load pointer/counter, swap control, bank_valid bookkeeping, and per-channel output muxing/zeroing.

Test Plan:
- Bench parameters for all scenarios: ADDR_W=3, DATA_W=11, NUM_RD=2.
- Reset, then rd_en=2'b11 at addr 0 -> rd_valid=00, rd_data=0, active_valid=0; swap_req -> swap_err pulse, active_bank stays 0.
- Load values 100..107 -> wr_count=8, shadow_full=1, wr_ready=0; 9th wr_valid ignored; swap_req -> swap_ack next cycle, active_bank=1, active_valid=1.
- Read ch0 addr 3 and ch1 addr 7 in the same cycle -> next cycle rd_data = {107, 103}, rd_valid=11; with rd_en=0 the data holds and valid=0.
- Load 200..207 into shadow while ch0 streams reads of addr 5 -> ch0 returns 105 throughout; swap in cycle t with a read at t -> 105 at t+1, read at t+1 -> 205 at t+2.
- Load 4 entries, then load_restart together with wr_valid -> wr_count=0, that write discarded; reload 8 entries -> shadow_full=1; assert reset_n=0 mid-load -> all outputs 0 immediately (async).
